tt_sweep_checker: RTL

Self-checking exhaustive stimulus engine for combinational blocks with N inputs and one output. On start it drives every one of the 2^N_IN input vectors and holds each for HOLD cycles. At the end of each hold window it samples the DUT output and compares it against a truth-table parameter. It reports a mismatch count and the first failing vector. It sits beside the circuit under test in on-chip self-test and lab harnesses.

---
 rtl/tt_sweep_pkg.sv | 21 ++
 rtl/tt_hold_timer.sv | 27 ++
 rtl/tt_sweep_checker.sv | 112 +++++++++++
 3 files changed

// File: rtl/tt_sweep_pkg.sv
// Shared types and helpers for the truth-table sweep checker.
// Gray-code ordering is selected at build time with TT_SWEEP_GRAY_EN.
package tt_sweep_pkg;

  localparam int MAX_N_IN = 8;

  typedef enum logic [1:0] {
    IDLE,
    DRIVE,
    DONE
  } sweep_state_t;

  function automatic int vec_count(input int n_in);
    return 1 << n_in;
  endfunction

  function automatic logic [MAX_N_IN-1:0] bin2gray(input logic [MAX_N_IN-1:0] bin);
    return bin ^ (bin >> 1);
  endfunction

endpackage

// File: rtl/tt_hold_timer.sv
// Hold-window timer: counts 0..HOLD-1 and wraps, flagging the final cycle.
module tt_hold_timer #(
  parameter int HOLD = 10
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  output logic last
);

  localparam int CNT_W = (HOLD > 1) ? $clog2(HOLD) : 1;

  logic [CNT_W-1:0] cnt;

  assign last = (cnt == CNT_W'(HOLD - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clear || last) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/tt_sweep_checker.sv
// Exhaustive truth-table sweep of an N_IN-input combinational DUT with mismatch reporting.
// Define TT_SWEEP_GRAY_EN to drive vectors in Gray-code order instead of binary.
module tt_sweep_checker
  import tt_sweep_pkg::*;
#(
  parameter int                   N_IN     = 4,
  parameter int                   HOLD     = 10,
  parameter logic [(1<<N_IN)-1:0] EXPECTED = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  output logic [N_IN-1:0] vec_out,
  input  logic            dut_q,
  output logic            busy,
  output logic            done,
  output logic            pass,
  output logic [N_IN:0]   err_count,
  output logic            first_err_valid,
  output logic [N_IN-1:0] first_err_vec
);

  localparam int              NUM_VEC  = vec_count(N_IN);
  localparam logic [N_IN-1:0] LAST_IDX = N_IN'(NUM_VEC - 1);

  sweep_state_t    state;
  logic [N_IN-1:0] idx;
  logic            hold_last;
  logic            hold_clear;
  logic            mismatch;
  logic [N_IN:0]   err_next;

  function automatic logic [N_IN-1:0] order(input logic [N_IN-1:0] i);
`ifdef TT_SWEEP_GRAY_EN
    return N_IN'(bin2gray(MAX_N_IN'(i)));
`else
    return i;
`endif
  endfunction

  // The timer sits at zero outside DRIVE so every sweep starts a fresh window.
  assign hold_clear = (state != DRIVE);

  tt_hold_timer #(
    .HOLD(HOLD)
  ) u_hold_timer (
    .clk  (clk),
    .rst_n(rst_n),
    .clear(hold_clear),
    .last (hold_last)
  );

  // Expected bit is looked up by the vector actually driven, not by idx.
  assign mismatch = (dut_q != EXPECTED[vec_out]);
  assign err_next = err_count + (N_IN+1)'(mismatch);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= IDLE;
      idx             <= '0;
      vec_out         <= '0;
      busy            <= 1'b0;
      done            <= 1'b0;
      pass            <= 1'b0;
      err_count       <= '0;
      first_err_valid <= 1'b0;
      first_err_vec   <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state           <= DRIVE;
            idx             <= '0;
            vec_out         <= order('0);
            busy            <= 1'b1;
            done            <= 1'b0;
            pass            <= 1'b0;
            err_count       <= '0;
            first_err_valid <= 1'b0;
            first_err_vec   <= '0;
          end
        end

        DRIVE: begin
          if (hold_last) begin
            err_count <= err_next;
            if (mismatch && !first_err_valid) begin
              first_err_valid <= 1'b1;
              first_err_vec   <= vec_out;
            end
            // vec_out keeps the final vector once the sweep has finished.
            if (idx == LAST_IDX) begin
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
              pass  <= (err_next == '0);
            end else begin
              idx     <= idx + N_IN'(1);
              vec_out <= order(idx + N_IN'(1));
            end
          end
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
